// File: rtl/unsat_select_ctrl_pkg.sv
// Shared definitions for the unsat clause selector controller.
package unsat_select_ctrl_pkg;

  // Controller phases: dividing an entry, writing an entry, serving requests.
  typedef enum logic [1:0] {
    ST_DIV = 2'd0,
    ST_WR  = 2'd1,
    ST_RUN = 2'd2
  } state_e;

  // One quotient bit per cycle over the 33-bit dividend 2^32 + i - 1.
  localparam int DIV_CYCLES = 33;

  // Saturated reciprocal used for m == 1.
  localparam logic [31:0] SAT_ONE = 32'hFFFF_FFFF;

  // Address width needed to index a buffer of the given depth.
  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/unsat_select_ctrl_recip_div.sv
// Restoring divider producing ceil(2^32 / divisor) for divisor >= 2.
// done is high during the final iteration; quotient is valid from the next cycle.
module unsat_select_ctrl_recip_div
  import unsat_select_ctrl_pkg::*;
#(
  parameter int AW = 11
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] divisor,
  output logic          done,
  output logic [31:0]   quotient
);

  localparam int QW = DIV_CYCLES;
  localparam logic [QW-1:0] TWO_POW_32 = {1'b1, {(QW-1){1'b0}}};

  logic [5:0]    cnt_q, cnt_d;
  logic [QW-1:0] acc_q, acc_d;   // dividend bits shift out the top, quotient bits shift in
  logic [AW:0]   rem_q, rem_d;
  logic [AW-1:0] dvs_q, dvs_d;
  logic [AW:0]   trial;

  // Load the rounded-up dividend on start, then retire one quotient bit per cycle.
  always_comb begin
    cnt_d = cnt_q;
    acc_d = acc_q;
    rem_d = rem_q;
    dvs_d = dvs_q;
    trial = (AW+1)'({rem_q, acc_q[QW-1]});
    if (start) begin
      cnt_d = 6'(DIV_CYCLES);
      acc_d = TWO_POW_32 + QW'(divisor) - QW'(1);
      rem_d = '0;
      dvs_d = divisor;
    end else if (cnt_q != 6'd0) begin
      cnt_d = cnt_q - 6'd1;
      if (trial >= {1'b0, dvs_q}) begin
        rem_d = trial - {1'b0, dvs_q};
        acc_d = {acc_q[QW-2:0], 1'b1};
      end else begin
        rem_d = trial;
        acc_d = {acc_q[QW-2:0], 1'b0};
      end
    end
  end

  // Iteration counter is control state and restarts on reset.
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // Datapath registers carry no reset.
  always_ff @(posedge clk) begin
    acc_q <= acc_d;
    rem_q <= rem_d;
    dvs_q <= dvs_d;
  end

  assign done     = (cnt_q == 6'd1);
  assign quotient = acc_q[31:0];

endmodule

// File: rtl/unsat_select_ctrl.sv
// Front-end controller for Unsat_Clause_Selector: loads its 1/m table after
// reset or rebuild, then issues tagged requests and returns tagged indices.
module unsat_select_ctrl
  import unsat_select_ctrl_pkg::*;
#(
  parameter int  BUFFER_DEPTH  = 2048,
  parameter int  M_TABLE_WIDTH = 32,
  parameter int  TAG_W         = 4,
  parameter int  SEL_LATENCY   = 3,
  localparam int AW            = addr_w(BUFFER_DEPTH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     rebuild_i,
  output logic                     init_done_o,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [AW-1:0]            req_count_i,
  input  logic [31:0]              req_rand_i,
  input  logic [TAG_W-1:0]         req_tag_i,
  output logic                     rsp_valid_o,
  output logic [AW-1:0]            rsp_index_o,
  output logic [TAG_W-1:0]         rsp_tag_o,
  output logic                     rsp_err_o,
  output logic                     sel_setup_o,
  output logic [AW-1:0]            sel_write_addr_o,
  output logic [M_TABLE_WIDTH-1:0] sel_mt_data_o,
  output logic                     sel_mt_en_o,
  output logic [AW-1:0]            sel_count_o,
  output logic [31:0]              sel_random_o,
  input  logic [AW-1:0]            sel_index_i
);

  // The response register is the last tracking stage, so the in-flight pipe
  // holds SEL_LATENCY-1 stages and sel_index_i is sampled one cycle before
  // the response is presented.
  localparam int LAST = SEL_LATENCY - 2;

  state_e                          state_q, state_d;
  logic [AW-1:0]                   addr_q, addr_d;
  logic                            div_start, div_done;
  logic [31:0]                     div_quot, entry;
  logic                            in_run, issue;
  logic [AW-1:0]                   count_q, count_d;
  logic [31:0]                     rand_q, rand_d;
  logic [SEL_LATENCY-2:0]          vld_p_q, vld_p_d, err_p_q, err_p_d;
  logic [SEL_LATENCY-2:0][TAG_W-1:0] tag_p_q, tag_p_d;
  logic                            rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [AW-1:0]                   rsp_index_q, rsp_index_d;
  logic [TAG_W-1:0]                rsp_tag_q, rsp_tag_d;

  unsat_select_ctrl_recip_div #(.AW(AW)) u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start),
    .divisor  (addr_d),
    .done     (div_done),
    .quotient (div_quot)
  );

  // Table-load sequencing: WR per entry, DIV ahead of every entry from 2 up.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    div_start = 1'b0;
    unique case (state_q)
      ST_WR: begin
        if (addr_q == AW'(BUFFER_DEPTH - 1)) begin
          state_d = ST_RUN;
        end else begin
          addr_d = addr_q + AW'(1);
          if (addr_d < AW'(2)) begin
            state_d = ST_WR;
          end else begin
            state_d   = ST_DIV;
            div_start = 1'b1;
          end
        end
      end
      ST_DIV: if (div_done) state_d = ST_WR;
      ST_RUN: begin
        if (rebuild_i) begin
          state_d = ST_WR;
          addr_d  = '0;
        end
      end
      default: begin
        state_d = ST_WR;
        addr_d  = '0;
      end
    endcase
  end

  // Entries 0 and 1 bypass the divider.
  always_comb begin
    entry = div_quot;
    if (addr_q == '0)            entry = '0;
    else if (addr_q == AW'(1))   entry = SAT_ONE;
  end

  // Issue path and response tracking; m == 0 is flagged and its index masked.
  always_comb begin
    issue   = in_run & req_valid_i;
    count_d = issue ? req_count_i : count_q;
    rand_d  = issue ? req_rand_i  : rand_q;

    vld_p_d    = vld_p_q;
    err_p_d    = err_p_q;
    tag_p_d    = tag_p_q;
    vld_p_d[0] = issue;
    err_p_d[0] = (req_count_i == '0);
    tag_p_d[0] = req_tag_i;
    for (int k = 1; k <= LAST; k++) begin
      vld_p_d[k] = vld_p_q[k-1];
      err_p_d[k] = err_p_q[k-1];
      tag_p_d[k] = tag_p_q[k-1];
    end

    rsp_valid_d = vld_p_q[LAST];
    rsp_tag_d   = rsp_tag_q;
    rsp_err_d   = rsp_err_q;
    rsp_index_d = rsp_index_q;
    if (vld_p_q[LAST]) begin
      rsp_tag_d   = tag_p_q[LAST];
      rsp_err_d   = err_p_q[LAST];
      rsp_index_d = err_p_q[LAST] ? '0 : sel_index_i;
    end
  end

  // Control state and response registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_WR;
      addr_q      <= '0;
      vld_p_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_index_q <= '0;
      rsp_tag_q   <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      vld_p_q     <= vld_p_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_index_q <= rsp_index_d;
      rsp_tag_q   <= rsp_tag_d;
    end
  end

  // Held selector operands and in-flight tag/err payload carry no reset.
  always_ff @(posedge clk) begin
    count_q <= count_d;
    rand_q  <= rand_d;
    err_p_q <= err_p_d;
    tag_p_q <= tag_p_d;
  end

  assign in_run           = (state_q == ST_RUN);
  assign init_done_o      = in_run;
  assign req_ready_o      = in_run;
  assign sel_setup_o      = (state_q == ST_WR) & ~reset;
  assign sel_write_addr_o = addr_q;
  assign sel_mt_data_o    = M_TABLE_WIDTH'(entry);
  assign sel_mt_en_o      = issue & ~sel_setup_o;
  assign sel_count_o      = count_d;
  assign sel_random_o     = rand_d;
  assign rsp_valid_o      = rsp_valid_q;
  assign rsp_index_o      = rsp_index_q;
  assign rsp_tag_o        = rsp_tag_q;
  assign rsp_err_o        = rsp_err_q;

endmodule

// File: tb/tb_unsat_select_ctrl.sv
// Bench for unsat_select_ctrl with a behavioural selector attached.
module tb_unsat_select_ctrl;

  localparam int BD       = 256;
  localparam int AW       = $clog2(BD);
  localparam int TAG_W    = 4;
  localparam int SEL_LAT  = 3;
  localparam int LOAD     = 2 + (BD - 2) * 34;
  localparam int WATCHDOG = 60000;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              rebuild_i = 1'b0;
  logic              init_done_o;
  logic              req_valid_i = 1'b0;
  logic              req_ready_o;
  logic [AW-1:0]     req_count_i = '0;
  logic [31:0]       req_rand_i = '0;
  logic [TAG_W-1:0]  req_tag_i = '0;
  logic              rsp_valid_o;
  logic [AW-1:0]     rsp_index_o;
  logic [TAG_W-1:0]  rsp_tag_o;
  logic              rsp_err_o;
  logic              sel_setup_o;
  logic [AW-1:0]     sel_write_addr_o;
  logic [31:0]       sel_mt_data_o;
  logic              sel_mt_en_o;
  logic [AW-1:0]     sel_count_o;
  logic [31:0]       sel_random_o;
  logic [AW-1:0]     sel_index_i;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int               due;
    logic [AW-1:0]    idx;
    logic [TAG_W-1:0] tag;
    logic             err;
  } exp_t;

  unsat_select_ctrl #(
    .BUFFER_DEPTH (BD),
    .M_TABLE_WIDTH(32),
    .TAG_W        (TAG_W),
    .SEL_LATENCY  (SEL_LAT)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .rebuild_i       (rebuild_i),
    .init_done_o     (init_done_o),
    .req_valid_i     (req_valid_i),
    .req_ready_o     (req_ready_o),
    .req_count_i     (req_count_i),
    .req_rand_i      (req_rand_i),
    .req_tag_i       (req_tag_i),
    .rsp_valid_o     (rsp_valid_o),
    .rsp_index_o     (rsp_index_o),
    .rsp_tag_o       (rsp_tag_o),
    .rsp_err_o       (rsp_err_o),
    .sel_setup_o     (sel_setup_o),
    .sel_write_addr_o(sel_write_addr_o),
    .sel_mt_data_o   (sel_mt_data_o),
    .sel_mt_en_o     (sel_mt_en_o),
    .sel_count_o     (sel_count_o),
    .sel_random_o    (sel_random_o),
    .sel_index_i     (sel_index_i)
  );

  always #5 clk = ~clk;

  // Behavioural selector: table written via setup port, index = N mod m
  // obtained from the stored reciprocal, presented two edges after issue.
  logic [31:0]   mt [BD];
  logic [AW-1:0] s1_m;
  logic [17:0]   s1_n;

  function automatic logic [AW-1:0] sel_model(input logic [AW-1:0] m, input logic [17:0] n);
    longint unsigned q, r;
    q = (longint'(n) * longint'(mt[m])) >> 32;
    r = longint'(n) - q * longint'(m);
    if (r >= longint'(m)) r = r - longint'(m);
    return AW'(r);
  endfunction

  always @(posedge clk) begin
    if (sel_setup_o) mt[sel_write_addr_o] <= sel_mt_data_o;
    if (sel_mt_en_o) begin
      s1_m <= sel_count_o;
      s1_n <= sel_random_o[27:10];
    end
    sel_index_i <= sel_model(s1_m, s1_n);
  end

  // Reference arithmetic.
  function automatic logic [31:0] recip(input int i);
    longint unsigned num;
    if (i == 0) return 32'h0;
    if (i == 1) return 32'hFFFF_FFFF;
    num = 64'h1_0000_0000 + longint'(i) - 1;
    return 32'(num / longint'(i));
  endfunction

  function automatic logic [AW-1:0] ref_idx(input int m, input int n);
    if (m == 0) return '0;
    return AW'(n % m);
  endfunction

  // Load cycle in which entry a is written (cycle 0 = first cycle out of reset/rebuild).
  function automatic int wcyc(input int a);
    return (a < 2) ? a : 34 * a - 33;
  endfunction

  function automatic int first_addr(input int lc);
    int a;
    a = 0;
    while (wcyc(a) < lc) a++;
    return a;
  endfunction

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if ({init_done_o, req_ready_o, rsp_valid_o, rsp_err_o, sel_setup_o, sel_mt_en_o} !== 6'b0 ||
        rsp_index_o !== '0 || rsp_tag_o !== '0) begin
      errors++;
      $display("FAIL reset_state: done/rdy/vld/err/setup/en=%b%b%b%b%b%b idx=%0d tag=%0d, required all 0",
               init_done_o, req_ready_o, rsp_valid_o, rsp_err_o, sel_setup_o, sel_mt_en_o, rsp_index_o, rsp_tag_o);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Follows a table load from load cycle lc_start; returns after stop_addr is
  // written, or once init_done_o is due.
  task automatic test_load(input int lc_start, input int stop_addr);
    int lc, na;
    bit done, exp_set;
    lc = lc_start;
    na = first_addr(lc_start);
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (lc >= LOAD) begin
        checks++;
        if (init_done_o !== 1'b1 || req_ready_o !== 1'b1) begin
          errors++;
          $display("FAIL load_done: init_done=%b ready=%b at load cycle %0d, required 1 1", init_done_o, req_ready_o, lc);
        end
        done = 1'b1;
      end else begin
        checks++;
        if (init_done_o !== 1'b0 || req_ready_o !== 1'b0) begin
          errors++;
          $display("FAIL load_busy: init_done=%b ready=%b at load cycle %0d, required 0 0", init_done_o, req_ready_o, lc);
        end
        exp_set = (na < BD) && (lc == wcyc(na));
        checks++;
        if (sel_setup_o !== exp_set) begin
          errors++;
          $display("FAIL setup_strobe: setup=%b at load cycle %0d, required %b", sel_setup_o, lc, exp_set);
        end
        if (exp_set) begin
          checks++;
          if (sel_write_addr_o !== AW'(na)) begin
            errors++;
            $display("FAIL setup_addr: addr=%0d, required %0d", sel_write_addr_o, na);
          end
          checks++;
          if (sel_mt_data_o !== recip(na) || sel_mt_en_o !== 1'b0) begin
            errors++;
            $display("FAIL setup_data: addr %0d data=%h en=%b, required %h en=0", na, sel_mt_data_o, sel_mt_en_o, recip(na));
          end
          if (na == 2 || na == 3 || na == 7) begin
            checks++;
            if ((na == 2 && sel_mt_data_o !== 32'h8000_0000) ||
                (na == 3 && sel_mt_data_o !== 32'h5555_5556) ||
                (na == 7 && sel_mt_data_o !== 32'h2492_4925)) begin
              errors++;
              $display("FAIL setup_anchor: addr %0d data=%h", na, sel_mt_data_o);
            end
          end
          if (na == stop_addr) done = 1'b1;
          na++;
        end
      end
      @(posedge clk);
      #1;
      lc++;
    end
  endtask

  task automatic test_reset_midload();
    test_load(0, 200);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (sel_setup_o !== 1'b0 || init_done_o !== 1'b0) begin
      errors++;
      $display("FAIL midload_reset: setup=%b init_done=%b during reset, required 0 0", sel_setup_o, init_done_o);
    end
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    test_load(0, -1);
  endtask

  task automatic test_single();
    logic [31:0] r;
    r = $urandom;
    r[27:10] = 18'd13;
    req_valid_i = 1'b1; req_count_i = AW'(5); req_rand_i = r; req_tag_i = TAG_W'(3);
    @(negedge clk);
    checks++;
    if (sel_mt_en_o !== 1'b1 || sel_count_o !== AW'(5) || sel_random_o !== r) begin
      errors++;
      $display("FAIL issue_comb: en=%b cnt=%0d rnd=%h, required 1 5 %h", sel_mt_en_o, sel_count_o, sel_random_o, r);
    end
    @(posedge clk);
    #1;
    req_valid_i = 1'b0; req_count_i = AW'(7); req_rand_i = ~r;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) begin
        checks++;
        if (sel_mt_en_o !== 1'b0 || sel_count_o !== AW'(5) || sel_random_o !== r) begin
          errors++;
          $display("FAIL issue_hold: en=%b cnt=%0d rnd=%h, required 0 5 %h", sel_mt_en_o, sel_count_o, sel_random_o, r);
        end
      end
      checks++;
      if (rsp_valid_o !== (k == SEL_LAT)) begin
        errors++;
        $display("FAIL single_valid: rsp_valid=%b at +%0d, required %b", rsp_valid_o, k, k == SEL_LAT);
      end
      if (k >= SEL_LAT) begin
        checks++;
        if (rsp_index_o !== ref_idx(5, 13) || rsp_tag_o !== TAG_W'(3) || rsp_err_o !== 1'b0) begin
          errors++;
          $display("FAIL single_rsp: idx=%0d tag=%0d err=%b at +%0d, required %0d 3 0", rsp_index_o, rsp_tag_o, rsp_err_o, k, ref_idx(5, 13));
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_back_to_back();
    int m [3];
    int n [3];
    m[0] = 1;      n[0] = 9;
    m[1] = 0;      n[1] = int'($urandom_range(0, 262143));
    m[2] = BD - 1; n[2] = 4100;
    for (int c = 0; c < 7; c++) begin
      if (c < 3) begin
        req_valid_i = 1'b1;
        req_count_i = AW'(m[c]);
        req_rand_i  = {4'($urandom), 18'(n[c]), 10'($urandom)};
        req_tag_i   = TAG_W'(c + 1);
      end else begin
        req_valid_i = 1'b0;
        req_count_i = AW'($urandom);
      end
      @(negedge clk);
      checks++;
      if (rsp_valid_o !== (c >= 3 && c < 6)) begin
        errors++;
        $display("FAIL b2b_valid: rsp_valid=%b at cycle %0d", rsp_valid_o, c);
      end
      if (c >= 3 && c < 6) begin
        checks++;
        if (rsp_index_o !== ref_idx(m[c-3], n[c-3]) || rsp_tag_o !== TAG_W'(c - 2) || rsp_err_o !== (m[c-3] == 0)) begin
          errors++;
          $display("FAIL b2b_rsp: idx=%0d tag=%0d err=%b, required %0d %0d %b",
                   rsp_index_o, rsp_tag_o, rsp_err_o, ref_idx(m[c-3], n[c-3]), c - 2, m[c-3] == 0);
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_random(input int n_cyc);
    exp_t q[$];
    exp_t e;
    bit v;
    int m, nn;
    for (int c = 0; c < n_cyc + SEL_LAT + 1; c++) begin
      v  = (c < n_cyc) && ($urandom_range(0, 3) != 0);
      m  = ($urandom_range(0, 31) == 0) ? 0 : int'($urandom_range(1, BD - 1));
      nn = int'($urandom_range(0, 262143));
      req_valid_i = v;
      req_count_i = AW'(m);
      req_rand_i  = {4'($urandom), 18'(nn), 10'($urandom)};
      req_tag_i   = TAG_W'($urandom);
      @(negedge clk);
      if (q.size() > 0 && q[0].due == c) begin
        e = q.pop_front();
        checks++;
        if (rsp_valid_o !== 1'b1 || rsp_index_o !== e.idx || rsp_tag_o !== e.tag || rsp_err_o !== e.err) begin
          errors++;
          $display("FAIL rand_rsp: vld=%b idx=%0d tag=%0d err=%b, required 1 %0d %0d %b",
                   rsp_valid_o, rsp_index_o, rsp_tag_o, rsp_err_o, e.idx, e.tag, e.err);
        end
      end else begin
        checks++;
        if (rsp_valid_o !== 1'b0) begin
          errors++;
          $display("FAIL rand_idle: rsp_valid=%b at cycle %0d, required 0", rsp_valid_o, c);
        end
      end
      if (v && req_ready_o) q.push_back('{c + SEL_LAT, ref_idx(m, nn), req_tag_i, m == 0});
      @(posedge clk);
      #1;
    end
    req_valid_i = 1'b0;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL rand_drain: %0d responses outstanding, required 0", q.size());
    end
  endtask

  task automatic test_rebuild();
    int m [2];
    int n [2];
    for (int i = 0; i < 2; i++) begin
      m[i] = int'($urandom_range(2, BD - 1));
      n[i] = int'($urandom_range(0, 262143));
    end
    for (int c = 0; c < 5; c++) begin
      req_valid_i = (c < 2);
      rebuild_i   = (c == 1);
      if (c < 2) begin
        req_count_i = AW'(m[c]);
        req_rand_i  = {4'($urandom), 18'(n[c]), 10'($urandom)};
        req_tag_i   = TAG_W'(c + 8);
      end
      @(negedge clk);
      checks++;
      if (req_ready_o !== (c < 2) || init_done_o !== (c < 2)) begin
        errors++;
        $display("FAIL rebuild_ready: ready=%b init_done=%b at cycle %0d, required %b", req_ready_o, init_done_o, c, c < 2);
      end
      checks++;
      if (sel_setup_o !== (c == 2 || c == 3) ||
          (c == 2 && (sel_write_addr_o !== AW'(0) || sel_mt_data_o !== 32'h0)) ||
          (c == 3 && (sel_write_addr_o !== AW'(1) || sel_mt_data_o !== 32'hFFFF_FFFF))) begin
        errors++;
        $display("FAIL rebuild_setup: setup=%b addr=%0d data=%h at cycle %0d", sel_setup_o, sel_write_addr_o, sel_mt_data_o, c);
      end
      checks++;
      if (rsp_valid_o !== (c >= 3)) begin
        errors++;
        $display("FAIL rebuild_valid: rsp_valid=%b at cycle %0d, required %b", rsp_valid_o, c, c >= 3);
      end
      if (c >= 3) begin
        checks++;
        if (rsp_index_o !== ref_idx(m[c-3], n[c-3]) || rsp_tag_o !== TAG_W'(c + 5) || rsp_err_o !== 1'b0) begin
          errors++;
          $display("FAIL rebuild_rsp: idx=%0d tag=%0d err=%b, required %0d %0d 0",
                   rsp_index_o, rsp_tag_o, rsp_err_o, ref_idx(m[c-3], n[c-3]), c + 5);
        end
      end
      @(posedge clk);
      #1;
    end
    req_valid_i = 1'b0;
    rebuild_i   = 1'b0;
    test_load(3, -1);
  endtask

  initial begin
    test_reset();
    test_reset_midload();
    test_single();
    test_back_to_back();
    test_random(5000);
    test_rebuild();
    test_random(300);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #(WATCHDOG * 10);
    $display("FAIL watchdog: run exceeded %0d cycles", WATCHDOG);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/unsat_select_ctrl.md
Name: unsat_select_ctrl

Overview:
Controller in front of Unsat_Clause_Selector.
- After reset it generates the selector's 1/m table itself: rounded-up 32-bit reciprocals, computed by an iterative divider and written through the selector's setup port.
- It then arbitrates a single tagged request stream from the WalkSAT step logic into the selector's 3-stage pipeline and returns a tagged, validated clause index.
- It hides table-load sequencing, pipeline latency and the m==0 hazard from the rest of the solver.

Parameters:
BUFFER_DEPTH, 2048, unsat buffer depth; also the number of table entries; AW = $clog2(BUFFER_DEPTH).
M_TABLE_WIDTH, 32, reciprocal width (all fractional bits).
TAG_W, 4, request tag width.
SEL_LATENCY, 3, selector input-to-selected_o latency in cycles.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
rebuild_i  in  1  pulse: reload table (honoured only in RUN)
init_done_o  out  1  high when table loaded and requests accepted
req_valid_i  in  1  request present
req_ready_o  out  1  request accepted when valid&ready
req_count_i  in  AW  unsat buffer count m
req_rand_i  in  32  random word, passed unchanged
req_tag_i  in  TAG_W  requester tag
rsp_valid_o  out  1  one-cycle result pulse, no backpressure
rsp_index_o  out  AW  selected index
rsp_tag_o  out  TAG_W  tag of the request
rsp_err_o  out  1  request had m==0; index forced 0
sel_setup_o  out  1  to selector setup
sel_write_addr_o  out  AW  to selector write_addr_i
sel_mt_data_o  out  M_TABLE_WIDTH  to selector mt_data_i
sel_mt_en_o  out  1  to selector mt_en_i
sel_count_o  out  AW  to selector unsat_buffer_count_i
sel_random_o  out  32  to selector random_i
sel_index_i  in  AW  from selector selected_o

Behaviour:
- Reset (synchronous, active-high): state=WR, addr=0, init_done_o=0, req_ready_o=0, rsp_valid_o=0, rsp_err_o=0, rsp_index_o=0, rsp_tag_o=0, sel_setup_o=0, sel_mt_en_o=0, valid pipe cleared. Asserting reset in any state, including mid-load, restarts the load from addr 0.
- FSM states: DIV, WR, RUN.
  - WR: sel_setup_o=1 for exactly one cycle with sel_write_addr_o=addr and sel_mt_data_o=entry.
  - Entries: addr 0 -> 0; addr 1 -> all-ones (saturated); addr i>=2 -> ceil(2^32/i), i.e. floor((2^32+i-1)/i).
  - After WR: if addr==BUFFER_DEPTH-1, go to RUN; else addr+1, then WR if the new addr<2, otherwise DIV.
  - DIV: exactly 33 cycles of restoring division (33-bit dividend, AW-bit divisor), then WR.
  - Load time: init_done_o rises at cycle 2+(BUFFER_DEPTH-2)*34 after reset release, i.e. 69566 for the default.
  - RUN: init_done_o=1, req_ready_o=1. On rebuild_i: init_done_o and req_ready_o drop the next cycle, addr=0, state=WR. In-flight results still drain.
- Issue (RUN, cycle T, req_valid_i & req_ready_o):
  - sel_mt_en_o=1, sel_count_o=req_count_i, sel_random_o=req_rand_i, all combinational in cycle T.
  - Outside issue cycles: sel_mt_en_o=0 and sel_count_o/sel_random_o hold their last values.
  - sel_mt_en_o is forced 0 whenever sel_setup_o=1.
- Tracking: SEL_LATENCY-deep shift register of {valid, tag, err}; err = (req_count_i==0).
- Response: at T+SEL_LATENCY, rsp_valid_o=1, rsp_tag_o=tag, rsp_err_o=err, rsp_index_o = err ? 0 : sel_index_i.
  - One request per cycle; back-to-back issue gives back-to-back responses in order.
  - rsp_* outputs are registered. Between pulses rsp_valid_o=0 and the others hold.
- During WR/DIV no requests are accepted, so selector outputs that depend on an incomplete table are never reported.
- Arithmetic: divider remainder is AW+1 bits; the quotient's bit 32 can only be set for i=1, which bypasses the divider. sel_mt_data_o takes quotient[31:0].

Decomposition:
- Shared package: state encoding (DIV/WR/RUN), AW derivation, DIV_CYCLES=33 constant, SAT_ONE all-ones constant.
- One sub-module: recip_div. Inputs start, divisor. Outputs done and the 32-bit rounded-up quotient after 33 cycles.

Test Plan:
- Reset release -> sel_setup_o pulses with addr/data (0,0), (1,FFFFFFFF), (2,80000000), (3,55555556), (7,24924925); init_done_o=1 at cycle 69566.
- Reset asserted at addr 500 during DIV -> next setup write is addr 0; init_done_o timing restarts from the release.
- RUN with selector attached, req count=5, rand bits[27:10]=13, tag=3 -> rsp_valid_o exactly 3 cycles later with index 3, tag 3, err 0.
- Back-to-back reqs (m=1,N=9,tag1), (m=0,tag2), (m=2047,N=4100,tag3) -> consecutive rsps: index 0 err0; index 0 err1; index 6 err0.
- rebuild_i in RUN with 2 requests in flight -> both responses delivered; req_ready_o low next cycle; full reload rewrites addr 0..2047; init_done_o returns after 69566 cycles.
- Random m in 1..2047 and random N over 10k requests -> rsp_index_o == N mod m in every case.
